// File: rtl/request_latch.sv
// Elevator floor-request latch: registers new-request pulses, clears them on service,
// and derives direction hints, pending count and oldest-request marker.
module request_latch #(
  parameter int AGE_W = 8
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             N1,
  input  logic             N2,
  input  logic             N3,
  input  logic             N4,
  input  logic             N5,
  input  logic             pos1,
  input  logic             pos2,
  input  logic             pos3,
  input  logic             pos4,
  input  logic             pos5,
  input  logic             door_open,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic             R4,
  output logic             R5,
  output logic             req_here,
  output logic             req_above,
  output logic             req_below,
  output logic [2:0]       pending_cnt,
  output logic [2:0]       last_floor,
  output logic             oldest1,
  output logic             oldest2,
  output logic             oldest3,
  output logic             oldest4,
  output logic             oldest5
);

  logic [4:0]       newVec;
  logic [4:0]       posVec;
  logic             posValid;
  logic [2:0]       floorEnc;
  logic [4:0]       clrVec;

  logic [4:0]       req_q, req_d;
  logic [AGE_W-1:0] age_q [5];
  logic [AGE_W-1:0] age_d [5];
  logic [2:0]       lastFloor_q, lastFloor_d;

  logic [4:0]       oldestVec;
  logic [2:0]       cntSum;
  logic             hereAny, aboveAny, belowAny;
  logic             found;
  logic [AGE_W-1:0] bestAge;

  assign newVec = {N5, N4, N3, N2, N1};
  assign posVec = {pos5, pos4, pos3, pos2, pos1};

  always_comb begin
    posValid    = $onehot(posVec);
    floorEnc    = lastFloor_q;
    for (int i = 0; i < 5; i++) begin
      if (posVec[i]) floorEnc = 3'(i + 1);
    end
    lastFloor_d = posValid ? floorEnc : lastFloor_q;
    clrVec      = (door_open && posValid) ? posVec : 5'b00000;
    req_d       = (req_q | newVec) & ~clrVec;
    // An age restarts at zero on the edge a request is set and freezes at all-ones.
    for (int i = 0; i < 5; i++) begin
      if (!req_q[i] || clrVec[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != {AGE_W{1'b1}}) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 5'b00000;
      lastFloor_q <= 3'd1;
      for (int i = 0; i < 5; i++) age_q[i] <= '0;
    end else begin
      req_q       <= req_d;
      lastFloor_q <= lastFloor_d;
      for (int i = 0; i < 5; i++) age_q[i] <= age_d[i];
    end
  end

  // Derived outputs look only at registered state, never at this cycle's N or pos.
  always_comb begin
    cntSum    = 3'd0;
    hereAny   = 1'b0;
    aboveAny  = 1'b0;
    belowAny  = 1'b0;
    found     = 1'b0;
    bestAge   = '0;
    oldestVec = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (req_q[i]) begin
        cntSum = cntSum + 3'd1;
        if (3'(i + 1) == lastFloor_q) hereAny = 1'b1;
        if (3'(i + 1) > lastFloor_q) aboveAny = 1'b1;
        if (3'(i + 1) < lastFloor_q) belowAny = 1'b1;
        if (!found || age_q[i] > bestAge) begin
          found     = 1'b1;
          bestAge   = age_q[i];
          oldestVec = 5'b00001 << i;
        end
      end
    end
  end

  assign {R5, R4, R3, R2, R1} = req_q;
  assign {oldest5, oldest4, oldest3, oldest2, oldest1} = oldestVec;
  assign req_here    = hereAny;
  assign req_above   = aboveAny;
  assign req_below   = belowAny;
  assign pending_cnt = cntSum;
  assign last_floor  = lastFloor_q;

endmodule

// File: tb/tb_request_latch.sv
// Self-checking bench for request_latch: a behavioural model pushes expected outputs
// into a scoreboard queue as stimulus is applied; each test task pops and compares.
module tb_request_latch;
  localparam int AGE_W   = 8;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic ck, rst_n, door_open;
  logic N1, N2, N3, N4, N5;
  logic pos1, pos2, pos3, pos4, pos5;
  logic R1, R2, R3, R4, R5;
  logic req_here, req_above, req_below;
  logic [2:0] pending_cnt, last_floor;
  logic oldest1, oldest2, oldest3, oldest4, oldest5;

  request_latch #(.AGE_W(AGE_W)) dut (
    .ck(ck), .rst_n(rst_n),
    .N1(N1), .N2(N2), .N3(N3), .N4(N4), .N5(N5),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .door_open(door_open),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5),
    .req_here(req_here), .req_above(req_above), .req_below(req_below),
    .pending_cnt(pending_cnt), .last_floor(last_floor),
    .oldest1(oldest1), .oldest2(oldest2), .oldest3(oldest3),
    .oldest4(oldest4), .oldest5(oldest5)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Output vector layout: R[5:1], here, above, below, cnt[2:0], last[2:0], oldest[5:1]
  logic [18:0] obsVec;
  assign obsVec = {R5, R4, R3, R2, R1, req_here, req_above, req_below,
                   pending_cnt, last_floor, oldest5, oldest4, oldest3, oldest2, oldest1};

  logic [18:0] sb[$];
  logic [18:0] exp;
  int errors = 0;
  int checks = 0;

  logic [4:0] mR;
  int         mAge [5];
  int         mLast;

  function automatic logic [18:0] modelOut();
    logic [4:0] old;
    logic       h, a, b;
    int         cnt, maxAge;
    h = 0; a = 0; b = 0; cnt = 0; maxAge = -1; old = 5'b0;
    for (int f = 1; f <= 5; f++) begin
      if (mR[f-1]) begin
        cnt++;
        if (f == mLast) h = 1;
        else if (f > mLast) a = 1;
        else b = 1;
        if (mAge[f-1] > maxAge) maxAge = mAge[f-1];
      end
    end
    for (int f = 5; f >= 1; f--) begin
      if (mR[f-1] && mAge[f-1] == maxAge) old = 5'b00001 << (f - 1);
    end
    return {mR, h, a, b, 3'(cnt), 3'(mLast), old};
  endfunction

  task automatic resetModel();
    mR = 5'b0;
    mLast = 1;
    for (int i = 0; i < 5; i++) mAge[i] = 0;
  endtask

  // Drive one cycle of stimulus, advance the model, queue its expectation.
  task automatic applyStimulus(input logic [4:0] n, input logic [4:0] p, input logic d);
    logic valid;
    logic clr;
    {N5, N4, N3, N2, N1} = n;
    {pos5, pos4, pos3, pos2, pos1} = p;
    door_open = d;
    valid = ($countones(p) == 1);
    for (int i = 0; i < 5; i++) begin
      clr = d && valid && p[i];
      if (!mR[i] || clr) mAge[i] = 0;
      else if (mAge[i] < AGE_MAX) mAge[i] = mAge[i] + 1;
      if (clr) mR[i] = 1'b0;
      else if (n[i]) mR[i] = 1'b1;
      if (valid && p[i]) mLast = i + 1;
    end
    sb.push_back(modelOut());
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(5'b00100, 5'b00000, 1'b0);
    resetModel();
    void'(sb.pop_front());
    exp = modelOut();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL reset_hold got %h want %h", obsVec, exp); end
    #2 rst_n = 1'b1;
    applyStimulus(5'b00100, 5'b00000, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || !R3 || !req_above || pending_cnt !== 3'd1) begin
      errors++; $display("[TB] FAIL first_set got %h want %h", obsVec, exp);
    end
    applyStimulus(5'b00000, 5'b00100, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL clear_r3 got %h want %h", obsVec, exp); end
  endtask

  task automatic test_multi_set();
    applyStimulus(5'b10010, 5'b00001, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || pending_cnt !== 3'd2) begin
      errors++; $display("[TB] FAIL multi_set got %h want %h", obsVec, exp);
    end
    for (int c = 0; c < 300; c++) begin
      applyStimulus(5'b00000, 5'b00000, 1'b0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== exp) begin errors++; $display("[TB] FAIL age_run c=%0d got %h want %h", c, obsVec, exp); end
    end
    checks++;
    if (!oldest2 || oldest5) begin errors++; $display("[TB] FAIL tie_oldest2 got %b want 1", oldest2); end
    applyStimulus(5'b00000, 5'b00010, 1'b1);
    void'(sb.pop_front());
    applyStimulus(5'b00000, 5'b10000, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL drain got %h want %h", obsVec, exp); end
  endtask

  // Floor 5 requested well before floor 2: oldest moves to 2 only once both saturate.
  task automatic test_saturation();
    applyStimulus(5'b10000, 5'b00000, 1'b0);
    void'(sb.pop_front());
    for (int c = 0; c < 320; c++) begin
      applyStimulus((c == 40) ? 5'b00010 : 5'b00000, 5'b00000, 1'b0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== exp) begin errors++; $display("[TB] FAIL sat c=%0d got %h want %h", c, obsVec, exp); end
    end
    checks++;
    if (!oldest2) begin errors++; $display("[TB] FAIL sat_tie got %b want 1", oldest2); end
    applyStimulus(5'b00000, 5'b00010, 1'b1);
    void'(sb.pop_front());
    applyStimulus(5'b00000, 5'b10000, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_clear_wins();
    applyStimulus(5'b01010, 5'b00000, 1'b0);
    void'(sb.pop_front());
    applyStimulus(5'b00000, 5'b00100, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL arrive3 got %h want %h", obsVec, exp); end
    applyStimulus(5'b00100, 5'b00100, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || R3 || !req_above || !req_below || req_here) begin
      errors++; $display("[TB] FAIL clear_wins got %h want %h", obsVec, exp);
    end
  endtask

  task automatic test_service();
    applyStimulus(5'b00000, 5'b01000, 1'b0);
    void'(sb.pop_front());
    applyStimulus(5'b00000, 5'b01000, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || R4 || pending_cnt !== 3'd1) begin
      errors++; $display("[TB] FAIL service4 got %h want %h", obsVec, exp);
    end
    applyStimulus(5'b01000, 5'b00000, 1'b0);
    void'(sb.pop_front());
    for (int c = 0; c < 4; c++) begin
      applyStimulus(5'b00000, 5'b00000, 1'b0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== exp) begin errors++; $display("[TB] FAIL reage4 c=%0d got %h want %h", c, obsVec, exp); end
    end
  endtask

  task automatic test_invalid_pos();
    applyStimulus(5'b11111, 5'b00000, 1'b0);
    void'(sb.pop_front());
    applyStimulus(5'b00000, 5'b00000, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || pending_cnt !== 3'd5) begin
      errors++; $display("[TB] FAIL pos_none got %h want %h", obsVec, exp);
    end
    applyStimulus(5'b00000, 5'b00110, 1'b1);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp || pending_cnt !== 3'd5) begin
      errors++; $display("[TB] FAIL pos_multi got %h want %h", obsVec, exp);
    end
  endtask

  task automatic test_async_reset();
    for (int f = 0; f < 5; f++) begin
      applyStimulus(5'b00000, 5'b00001 << f, 1'b1);
      void'(sb.pop_front());
    end
    applyStimulus(5'b10101, 5'b00000, 1'b0);
    void'(sb.pop_front());
    for (int c = 0; c < 6; c++) begin
      applyStimulus(5'b00000, 5'b00000, 1'b0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== exp) begin errors++; $display("[TB] FAIL run10101 c=%0d got %h want %h", c, obsVec, exp); end
    end
    #1 rst_n = 1'b0;
    resetModel();
    #1;
    exp = modelOut();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL async_reset got %h want %h", obsVec, exp); end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(5'b00000, 5'b00000, 1'b0);
      exp = sb.pop_front();
      checks++;
      if (obsVec !== exp) begin errors++; $display("[TB] FAIL post_reset c=%0d got %h want %h", c, obsVec, exp); end
    end
    applyStimulus(5'b00001, 5'b00000, 1'b0);
    exp = sb.pop_front();
    checks++;
    if (obsVec !== exp) begin errors++; $display("[TB] FAIL post_reset_set got %h want %h", obsVec, exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    door_open = 1'b0;
    {N5, N4, N3, N2, N1} = 5'b0;
    {pos5, pos4, pos3, pos2, pos1} = 5'b0;
    resetModel();
    test_reset();
    test_multi_set();
    test_saturation();
    test_clear_wins();
    test_service();
    test_invalid_pos();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/request_latch.md
# request_latch

Holds elevator floor requests. Each cycle it takes the new-request pulses N1..N5 from the input-decode stage and latches them into the registered requests R1..R5. R1..R5 are fed back to that stage as its mask. A request clears when the car is stopped at that floor with the door open. From the registered state the block derives direction hints (above, below, here), a pending count and the oldest-request floor for the controller FSM.

## Interface
Parameters:
- AGE_W, 8: width of each per-floor wait-age counter; the counter saturates at 2^AGE_W-1.

Ports:
- ck  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- N1..N5  in  1 each  new-request pulses, one per floor, from the input-decode stage.
- pos1..pos5  in  1 each  car-at-floor sensors; one-hot when the car is at a floor, all zero between floors.
- door_open  in  1  door is open; serves the request at the current floor.
- R1..R5  out  1 each  registered pending requests.
- req_here  out  1  a request is pending at last_floor.
- req_above  out  1  a request is pending at any floor above last_floor.
- req_below  out  1  a request is pending at any floor below last_floor.
- pending_cnt  out  3  number of R bits set (0..5).
- last_floor  out  3  last valid floor, binary 1..5.
- oldest1..oldest5  out  1 each  one-hot marker of the oldest pending request; all zero when no request is pending.

## Operation
- pos_valid = pos1..pos5 has exactly one bit set. A pattern with zero bits or with two or more bits is not valid.
- last_floor register:
  - loads the encoded floor when pos_valid;
  - otherwise holds.
- clr_i = door_open & pos_valid & pos_i.
- Next-state rule for R_i:
  - if clr_i: R_i <= 0 (clear wins over a simultaneous N_i);
  - else if N_i: R_i <= 1;
  - else: R_i holds.
- age_i counter, width AGE_W:
  - cleared to 0 whenever R_i is 0 or clr_i;
  - 0 on the edge that sets R_i;
  - increments by 1 each cycle while R_i = 1;
  - saturates at all-ones.
- oldest: the floor with R_i = 1 and the largest age_i. Ties go to the lowest floor number.
- req_here, req_above, req_below and pending_cnt are combinational from the R registers and last_floor only. They never depend on N or pos in the same cycle.
- When door_open is asserted while pos is not valid, nothing is cleared.
- Reset values (rst_n low, asynchronous, takes effect without ck):
  - R1..R5 = 0 and all age_i = 0;
  - last_floor = 1;
  - req_here, req_above and req_below = 0;
  - pending_cnt = 0 and oldest1..oldest5 = 0.
- Reset asserted mid-operation discards all pending requests immediately. After release, the first ck edge with N_i set latches that request normally.

## Timing
- N_i high at edge k sets R_i = 1 after edge k. The derived outputs reflect the change in the same cycle as R (combinational from the registers).
- Latency from N pulse to R: 1 cycle. Latency from service to R clear: 1 cycle after the edge with door_open & pos_i.
- last_floor updates 1 cycle after pos becomes valid. Direction flags computed in the cycle when the car arrives therefore still use the previous floor.
- Feedback loop: the decode stage masks N with R. The loop stays legal because R is registered; there is no combinational path from N to R.
- The age counter reads 1 on the cycle after the request is set. It reaches 2^AGE_W-1 and stays there.
- Multiple N bits in one cycle: all are latched independently. pending_cnt can jump by up to 5.

## Test plan
- Reset with N3 = 1 held: R = 00000, last_floor = 1 and all outputs 0. After rst_n rises, one edge gives R3 = 1, pending_cnt = 1 and req_above = 1.
- Car at floor 1 (pos1 = 1), N2 = 1 and N5 = 1 pulse on the same edge: R2 = R5 = 1 and pending_cnt = 2. 300 cycles later, AGE_W = 8: age of floor 2 is 255 (saturated) and oldest2 = 1 (tie broken to the lowest floor).
- pos3 = 1 with R2 = R4 = 1: req_above = 1, req_below = 1 and req_here = 0. With door_open = 1 and N3 pulsed on the same edge, R3 stays 0 (clear wins).
- R4 = 1, pos4 = 1, door_open = 1 for one edge: R4 = 0 the next cycle, age of floor 4 is 0 and pending_cnt drops by 1.
- pos = 00000 with door_open = 1 and R = 11111: nothing clears and last_floor holds its previous value. pos = 00110 (invalid) behaves the same.
- R = 10101 with ages running, then rst_n pulses low between edges: all outputs 0 immediately without a clock edge. After release they stay 0 until the next N pulse.
